// File: rtl/miet_axi_pkg.sv
// Shared AXI4 types for the SRAM responder: burst encodings,
// response codes and the read/write channel FSM states.
package miet_axi_pkg;

    typedef enum logic [1:0] {
        BURST_FIXED = 2'b00,
        BURST_INCR  = 2'b01,
        BURST_WRAP  = 2'b10
    } axi_burst_e;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_EXOKAY = 2'b01;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } wr_state_e;

    typedef enum logic [1:0] {
        R_IDLE,
        R_FETCH,
        R_DATA
    } rd_state_e;

    function automatic logic burst_ok(input logic [1:0] burst);
        return (burst == BURST_FIXED) || (burst == BURST_INCR);
    endfunction

endpackage

// File: rtl/axi4_if.sv
// AXI4 bundle shared by the interconnect master ports and responders.
// lock/cache/prot are carried but unused by simple memory targets.
interface axi4_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int ID_W   = 4
);
    logic [ADDR_W-1:0]   aw_addr;
    logic [ID_W-1:0]     aw_id;
    logic [7:0]          aw_len;
    logic [2:0]          aw_size;
    logic [1:0]          aw_burst;
    logic                aw_lock;
    logic [3:0]          aw_cache;
    logic [2:0]          aw_prot;
    logic                aw_valid;
    logic                aw_ready;

    logic [DATA_W-1:0]   w_data;
    logic [DATA_W/8-1:0] w_strb;
    logic                w_last;
    logic                w_valid;
    logic                w_ready;

    logic [ID_W-1:0]     b_id;
    logic [1:0]          b_resp;
    logic                b_valid;
    logic                b_ready;

    logic [ADDR_W-1:0]   ar_addr;
    logic [ID_W-1:0]     ar_id;
    logic [7:0]          ar_len;
    logic [2:0]          ar_size;
    logic [1:0]          ar_burst;
    logic                ar_lock;
    logic [3:0]          ar_cache;
    logic [2:0]          ar_prot;
    logic                ar_valid;
    logic                ar_ready;

    logic [DATA_W-1:0]   r_data;
    logic [ID_W-1:0]     r_id;
    logic [1:0]          r_resp;
    logic                r_last;
    logic                r_valid;
    logic                r_ready;

    modport Slave (
        input  aw_addr, aw_id, aw_len, aw_size, aw_burst,
        input  aw_lock, aw_cache, aw_prot, aw_valid,
        output aw_ready,
        input  w_data, w_strb, w_last, w_valid,
        output w_ready,
        output b_id, b_resp, b_valid,
        input  b_ready,
        input  ar_addr, ar_id, ar_len, ar_size, ar_burst,
        input  ar_lock, ar_cache, ar_prot, ar_valid,
        output ar_ready,
        output r_data, r_id, r_resp, r_last, r_valid,
        input  r_ready
    );

    modport Master (
        output aw_addr, aw_id, aw_len, aw_size, aw_burst,
        output aw_lock, aw_cache, aw_prot, aw_valid,
        input  aw_ready,
        output w_data, w_strb, w_last, w_valid,
        input  w_ready,
        input  b_id, b_resp, b_valid,
        output b_ready,
        output ar_addr, ar_id, ar_len, ar_size, ar_burst,
        output ar_lock, ar_cache, ar_prot, ar_valid,
        input  ar_ready,
        input  r_data, r_id, r_resp, r_last, r_valid,
        output r_ready
    );
endinterface

// File: rtl/miet_sram_1r1w.sv
// Simple dual-port SRAM: byte-enabled write port, registered read port.
// A read and write to the same word in one cycle returns the old data.
module miet_sram_1r1w #(
    parameter int DATA_W    = 32,
    parameter int MEM_DEPTH = 1024,
    parameter int IDX_W     = $clog2(MEM_DEPTH)
) (
    input  logic                i_clk,
    input  logic                we,
    input  logic [IDX_W-1:0]    waddr,
    input  logic [DATA_W/8-1:0] wstrb,
    input  logic [DATA_W-1:0]   wdata,
    input  logic                re,
    input  logic [IDX_W-1:0]    raddr,
    output logic [DATA_W-1:0]   rdata
);
    logic [DATA_W-1:0] mem [MEM_DEPTH];

    always_ff @(posedge i_clk) begin
        if (we) begin
            for (int i = 0; i < DATA_W/8; i++) begin
                if (wstrb[i]) begin
                    mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (re) begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/miet_axi4_sram_slave.sv
// AXI4 responder backed by on-chip SRAM; independent write and read
// channel FSMs, one outstanding transaction per direction.
module miet_axi4_sram_slave
    import miet_axi_pkg::*;
#(
    parameter int              ADDR_W    = 32,
    parameter int              DATA_W    = 32,
    parameter int              ID_W      = 4,
    parameter int              MEM_DEPTH = 1024,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0
) (
    input logic   i_clk,
    input logic   i_rst,
    axi4_if.Slave AXI4_S
);
    localparam int                OFF_W    = $clog2(DATA_W/8);
    localparam int                IDX_W    = $clog2(MEM_DEPTH);
    localparam logic [ADDR_W-1:0] DEPTH_A  = ADDR_W'(MEM_DEPTH);
    localparam logic [2:0]        MAX_SIZE = 3'(OFF_W);

    // Unsigned wrap makes addresses below BASE land out of range.
    function automatic logic [ADDR_W-1:0] word_idx(
        input logic [ADDR_W-1:0] a
    );
        return (a - BASE_ADDR) >> OFF_W;
    endfunction

    function automatic logic beat_bad(
        input logic [ADDR_W-1:0] idx,
        input logic [2:0]        size,
        input logic [1:0]        burst
    );
        return (idx >= DEPTH_A) || !burst_ok(burst) || (size > MAX_SIZE);
    endfunction

    function automatic logic [ADDR_W-1:0] addr_step(
        input logic [ADDR_W-1:0] a,
        input logic [2:0]        size,
        input logic [1:0]        burst
    );
        return (burst == BURST_INCR) ? a + (ADDR_W'(1) << size) : a;
    endfunction

    logic unused_in;
    assign unused_in = ^{AXI4_S.aw_lock, AXI4_S.aw_cache, AXI4_S.aw_prot,
                         AXI4_S.ar_lock, AXI4_S.ar_cache, AXI4_S.ar_prot};

    // ---------------- write channel ----------------
    wr_state_e         w_state, w_state_nx;
    logic [ADDR_W-1:0] w_addr;
    logic [ID_W-1:0]   w_id;
    logic [7:0]        w_len;
    logic [7:0]        w_cnt;
    logic [2:0]        w_size;
    logic [1:0]        w_burst;
    logic              w_err;
    logic [ADDR_W-1:0] w_idx;
    logic              w_bad;
    logic              w_final;
    logic              aw_hs;
    logic              w_hs;
    logic              b_hs;

    assign aw_hs   = AXI4_S.aw_valid && AXI4_S.aw_ready;
    assign w_hs    = AXI4_S.w_valid && AXI4_S.w_ready;
    assign b_hs    = AXI4_S.b_valid && AXI4_S.b_ready;
    assign w_idx   = word_idx(w_addr);
    assign w_bad   = beat_bad(w_idx, w_size, w_burst);
    assign w_final = (w_cnt == w_len);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            w_state <= W_IDLE;
        end else begin
            w_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = w_state;
        unique case (w_state)
            W_IDLE:  if (aw_hs) w_state_nx = W_DATA;
            W_DATA:  if (w_hs && w_final) w_state_nx = W_RESP;
            W_RESP:  if (b_hs) w_state_nx = W_IDLE;
            default: w_state_nx = W_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            w_addr  <= '0;
            w_id    <= '0;
            w_len   <= '0;
            w_cnt   <= '0;
            w_size  <= '0;
            w_burst <= '0;
            w_err   <= 1'b0;
        end else if (aw_hs) begin
            w_addr  <= AXI4_S.aw_addr;
            w_id    <= AXI4_S.aw_id;
            w_len   <= AXI4_S.aw_len;
            w_cnt   <= '0;
            w_size  <= AXI4_S.aw_size;
            w_burst <= AXI4_S.aw_burst;
            w_err   <= 1'b0;
        end else if (w_hs) begin
            w_cnt  <= w_cnt + 8'd1;
            w_addr <= addr_step(w_addr, w_size, w_burst);
            // w_last is only a consistency check; the counter ends the burst
            if (w_bad || (AXI4_S.w_last != w_final)) begin
                w_err <= 1'b1;
            end
        end
    end

    assign AXI4_S.aw_ready = (w_state == W_IDLE);
    assign AXI4_S.w_ready  = (w_state == W_DATA);
    assign AXI4_S.b_valid  = (w_state == W_RESP);
    assign AXI4_S.b_id     = w_id;
    assign AXI4_S.b_resp   = (w_state == W_RESP && w_err) ? RESP_SLVERR
                                                          : RESP_OKAY;

    // ---------------- read channel ----------------
    rd_state_e         r_state, r_state_nx;
    logic [ADDR_W-1:0] r_addr;
    logic [ID_W-1:0]   r_id_q;
    logic [7:0]        r_len;
    logic [7:0]        r_cnt;
    logic [2:0]        r_size;
    logic [1:0]        r_burst;
    logic              r_err;
    logic [ADDR_W-1:0] r_idx;
    logic              r_bad;
    logic              r_final;
    logic              ar_hs;
    logic              r_hs;
    logic [DATA_W-1:0] sram_q;

    assign ar_hs   = AXI4_S.ar_valid && AXI4_S.ar_ready;
    assign r_hs    = AXI4_S.r_valid && AXI4_S.r_ready;
    assign r_idx   = word_idx(r_addr);
    assign r_bad   = beat_bad(r_idx, r_size, r_burst);
    assign r_final = (r_cnt == r_len);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= R_IDLE;
        end else begin
            r_state <= r_state_nx;
        end
    end

    always_comb begin
        r_state_nx = r_state;
        unique case (r_state)
            R_IDLE:  if (ar_hs) r_state_nx = R_FETCH;
            R_FETCH: r_state_nx = R_DATA;
            R_DATA:  if (r_hs) r_state_nx = r_final ? R_IDLE : R_FETCH;
            default: r_state_nx = R_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_addr  <= '0;
            r_id_q  <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
            r_size  <= '0;
            r_burst <= '0;
            r_err   <= 1'b0;
        end else if (ar_hs) begin
            r_addr  <= AXI4_S.ar_addr;
            r_id_q  <= AXI4_S.ar_id;
            r_len   <= AXI4_S.ar_len;
            r_cnt   <= '0;
            r_size  <= AXI4_S.ar_size;
            r_burst <= AXI4_S.ar_burst;
            r_err   <= 1'b0;
        end else if (r_state == R_FETCH) begin
            r_err <= r_bad;
        end else if (r_hs) begin
            r_cnt  <= r_cnt + 8'd1;
            r_addr <= addr_step(r_addr, r_size, r_burst);
        end
    end

    assign AXI4_S.ar_ready = (r_state == R_IDLE);
    assign AXI4_S.r_valid  = (r_state == R_DATA);
    assign AXI4_S.r_id     = r_id_q;
    assign AXI4_S.r_last   = (r_state == R_DATA) && r_final;
    assign AXI4_S.r_resp   = (r_state == R_DATA && r_err) ? RESP_SLVERR
                                                          : RESP_OKAY;
    assign AXI4_S.r_data   = (r_state == R_DATA && !r_err) ? sram_q : '0;

    miet_sram_1r1w #(
        .DATA_W    (DATA_W),
        .MEM_DEPTH (MEM_DEPTH),
        .IDX_W     (IDX_W)
    ) u_sram (
        .i_clk (i_clk),
        .we    (w_hs && !w_bad && !i_rst),
        .waddr (w_idx[IDX_W-1:0]),
        .wstrb (AXI4_S.w_strb),
        .wdata (AXI4_S.w_data),
        .re    (r_state == R_FETCH),
        .raddr (r_idx[IDX_W-1:0]),
        .rdata (sram_q)
    );

endmodule

// File: tb/tb_miet_axi4_sram_slave.sv
// Directed bench for miet_axi4_sram_slave: drives on the falling edge,
// samples on the falling edge, checks against hand-computed values.
module tb_miet_axi4_sram_slave;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    axi4_if #(.ADDR_W(32), .DATA_W(32), .ID_W(4)) bus ();

    miet_axi4_sram_slave #(
        .ADDR_W    (32),
        .DATA_W    (32),
        .ID_W      (4),
        .MEM_DEPTH (1024),
        .BASE_ADDR (32'h0000_0000)
    ) dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .AXI4_S (bus)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    logic [31:0] wr_data [16];
    logic [3:0]  wr_strb [16];
    int          early_last = -1;
    logic [1:0]  b_resp_q;
    logic [3:0]  b_id_q;
    int          w_wait;
    int          b_wait;

    logic [31:0] rd_data [16];
    logic [1:0]  rd_resp [16];
    logic        rd_last [16];
    logic [3:0]  rd_id   [16];
    int          rd_n;
    int          rd_lat;

    task automatic send_aw(input logic [31:0] addr, input logic [3:0] id,
                           input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst);
        int n = 0;
        @(negedge clk);
        bus.aw_addr  = addr;
        bus.aw_id    = id;
        bus.aw_len   = len;
        bus.aw_size  = size;
        bus.aw_burst = burst;
        bus.aw_valid = 1'b1;
        while (!bus.aw_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("aw_tmo", bus.aw_ready, 1);
        @(negedge clk);
        bus.aw_valid = 1'b0;
    endtask

    task automatic send_ar(input logic [31:0] addr, input logic [3:0] id,
                           input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst);
        int n = 0;
        @(negedge clk);
        bus.ar_addr  = addr;
        bus.ar_id    = id;
        bus.ar_len   = len;
        bus.ar_size  = size;
        bus.ar_burst = burst;
        bus.ar_valid = 1'b1;
        while (!bus.ar_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("ar_tmo", bus.ar_ready, 1);
        @(negedge clk);
        bus.ar_valid = 1'b0;
    endtask

    task automatic write_burst(input logic [31:0] addr, input logic [3:0] id,
                               input logic [7:0] len, input logic [2:0] size,
                               input logic [1:0] burst);
        int n;
        send_aw(addr, id, len, size, burst);
        for (int i = 0; i <= int'(len); i++) begin
            bus.w_data  = wr_data[i];
            bus.w_strb  = wr_strb[i];
            bus.w_last  = (early_last >= 0) ? (i == early_last)
                                            : (i == int'(len));
            bus.w_valid = 1'b1;
            n = 0;
            while (!bus.w_ready && n < 50) begin
                @(negedge clk);
                n++;
            end
            if (n >= 50) begin
                chk("w_tmo", bus.w_ready, 1);
                break;
            end
            if (i == 0) w_wait = n;
            @(negedge clk);
        end
        bus.w_valid = 1'b0;
        bus.w_last  = 1'b0;
        n = 0;
        while (!bus.b_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) chk("b_tmo", bus.b_valid, 1);
        b_wait      = n;
        b_resp_q    = bus.b_resp;
        b_id_q      = bus.b_id;
        bus.b_ready = 1'b1;
        @(negedge clk);
        bus.b_ready = 1'b0;
    endtask

    task automatic collect();
        int   n    = 0;
        logic done = 1'b0;
        rd_n   = 0;
        rd_lat = -1;
        bus.r_ready = 1'b1;
        while (!done && n < 100) begin
            if (bus.r_valid) begin
                if (rd_n == 0) rd_lat = n;
                rd_data[rd_n] = bus.r_data;
                rd_resp[rd_n] = bus.r_resp;
                rd_last[rd_n] = bus.r_last;
                rd_id[rd_n]   = bus.r_id;
                done          = bus.r_last;
                if (rd_n < 15) rd_n++;
            end
            @(negedge clk);
            n++;
        end
        bus.r_ready = 1'b0;
        if (!done) chk("r_tmo", done, 1);
    endtask

    task automatic read_burst(input logic [31:0] addr, input logic [3:0] id,
                              input logic [7:0] len, input logic [2:0] size,
                              input logic [1:0] burst);
        send_ar(addr, id, len, size, burst);
        collect();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.aw_addr = '0; bus.aw_id = '0; bus.aw_len = '0;
        bus.aw_size = '0; bus.aw_burst = '0; bus.aw_valid = 1'b0;
        bus.aw_lock = 1'b0; bus.aw_cache = '0; bus.aw_prot = '0;
        bus.w_data = '0; bus.w_strb = '0; bus.w_last = 1'b0;
        bus.w_valid = 1'b0; bus.b_ready = 1'b0;
        bus.ar_addr = '0; bus.ar_id = '0; bus.ar_len = '0;
        bus.ar_size = '0; bus.ar_burst = '0; bus.ar_valid = 1'b0;
        bus.ar_lock = 1'b0; bus.ar_cache = '0; bus.ar_prot = '0;
        bus.r_ready = 1'b0;

        // reset values
        rst = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_aw_ready", bus.aw_ready, 1);
        chk("rst_ar_ready", bus.ar_ready, 1);
        chk("rst_w_ready",  bus.w_ready,  0);
        chk("rst_b_valid",  bus.b_valid,  0);
        chk("rst_r_valid",  bus.r_valid,  0);
        chk("rst_b_resp",   bus.b_resp,   0);
        chk("rst_r_resp",   bus.r_resp,   0);
        chk("rst_r_data",   bus.r_data,   0);
        chk("rst_r_last",   bus.r_last,   0);
        chk("rst_b_id",     bus.b_id,     0);
        chk("rst_r_id",     bus.r_id,     0);
        rst = 1'b0;

        // single write then read, with latency checks
        wr_data[0] = 32'hDEADBEEF; wr_strb[0] = 4'hF;
        write_burst(32'h10, 4'd3, 8'd0, 3'd2, 2'b01);
        chk("single_bresp", b_resp_q, 2'b00);
        chk("single_bid",   b_id_q,   4'd3);
        chk("w_ready_lat",  w_wait,   0);
        chk("b_valid_lat",  b_wait,   0);
        read_burst(32'h10, 4'd2, 8'd0, 3'd2, 2'b01);
        chk("single_rdata", rd_data[0], 32'hDEADBEEF);
        chk("single_rresp", rd_resp[0], 2'b00);
        chk("single_rlast", rd_last[0], 1);
        chk("single_rid",   rd_id[0],   4'd2);
        chk("r_valid_lat",  rd_lat,     1);

        // INCR burst of four
        for (int i = 0; i < 4; i++) begin
            wr_data[i] = 32'(i + 1);
            wr_strb[i] = 4'hF;
        end
        write_burst(32'h100, 4'd1, 8'd3, 3'd2, 2'b01);
        chk("incr_bresp", b_resp_q, 2'b00);
        read_burst(32'h100, 4'd5, 8'd3, 3'd2, 2'b01);
        chk("incr_nbeats", rd_n, 4);
        for (int i = 0; i < 4; i++) begin
            chk("incr_data", rd_data[i], 32'(i + 1));
            chk("incr_last", rd_last[i], (i == 3) ? 1 : 0);
            chk("incr_id",   rd_id[i],   4'd5);
        end

        // partial strobe
        wr_data[0] = 32'hAABBCCDD; wr_strb[0] = 4'hF;
        write_burst(32'h20, 4'd0, 8'd0, 3'd2, 2'b01);
        wr_data[0] = 32'h11223344; wr_strb[0] = 4'b0101;
        write_burst(32'h20, 4'd0, 8'd0, 3'd2, 2'b01);
        read_burst(32'h20, 4'd0, 8'd0, 3'd2, 2'b01);
        chk("strb_data", rd_data[0], 32'hAA22CC44);

        // FIXED read repeats the word
        read_burst(32'h20, 4'd4, 8'd1, 3'd2, 2'b00);
        chk("fixed_data0", rd_data[0], 32'hAA22CC44);
        chk("fixed_data1", rd_data[1], 32'hAA22CC44);
        chk("fixed_last0", rd_last[0], 0);
        chk("fixed_last1", rd_last[1], 1);

        // out-of-range write must not alias onto word 0
        wr_data[0] = 32'h12345678; wr_strb[0] = 4'hF;
        write_burst(32'h0, 4'd0, 8'd0, 3'd2, 2'b01);
        wr_data[0] = 32'hCAFEF00D;
        write_burst(32'h1000, 4'd9, 8'd0, 3'd2, 2'b01);
        chk("oor_bresp", b_resp_q, 2'b10);
        chk("oor_bid",   b_id_q,   4'd9);
        read_burst(32'h0, 4'd0, 8'd0, 3'd2, 2'b01);
        chk("oor_nochange", rd_data[0], 32'h12345678);

        // WRAP read errors every beat
        read_burst(32'h10, 4'd0, 8'd1, 3'd2, 2'b10);
        for (int i = 0; i < 2; i++) begin
            chk("wrap_resp", rd_resp[i], 2'b10);
            chk("wrap_data", rd_data[i], 0);
        end
        chk("wrap_last1", rd_last[1], 1);

        // early w_last: still three beats, then SLVERR
        for (int i = 0; i < 3; i++) begin
            wr_data[i] = 32'(7 + i);
            wr_strb[i] = 4'hF;
        end
        early_last = 0;
        write_burst(32'h200, 4'd2, 8'd2, 3'd2, 2'b01);
        early_last = -1;
        chk("early_last_bresp", b_resp_q, 2'b10);

        // R backpressure: outputs hold while r_ready low
        send_ar(32'h100, 4'd6, 8'd1, 3'd2, 2'b01);
        for (int n = 0; n < 50 && !bus.r_valid; n++) @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", bus.r_valid, 1);
            chk("bp_data",  bus.r_data,  32'h1);
            chk("bp_resp",  bus.r_resp,  2'b00);
            chk("bp_last",  bus.r_last,  0);
            @(negedge clk);
        end
        collect();
        chk("bp_beat1", rd_data[1], 32'h2);
        chk("bp_last1", rd_last[1], 1);

        // same-cycle read and write of 0x40
        wr_data[0] = 32'h0BADF00D; wr_strb[0] = 4'hF;
        write_burst(32'h40, 4'd0, 8'd0, 3'd2, 2'b01);
        wr_data[0] = 32'h600D600D;
        fork
            write_burst(32'h40, 4'd1, 8'd0, 3'd2, 2'b01);
            read_burst(32'h40, 4'd1, 8'd0, 3'd2, 2'b01);
        join
        chk("rw_old", rd_data[0], 32'h0BADF00D);
        read_burst(32'h40, 4'd1, 8'd0, 3'd2, 2'b01);
        chk("rw_new", rd_data[0], 32'h600D600D);

        // reset during a len-7 write
        send_aw(32'h300, 4'd7, 8'd7, 3'd2, 2'b01);
        for (int i = 0; i < 2; i++) begin
            bus.w_data  = 32'h11 * (i + 1);
            bus.w_strb  = 4'hF;
            bus.w_last  = 1'b0;
            bus.w_valid = 1'b1;
            for (int n = 0; n < 50 && !bus.w_ready; n++) @(negedge clk);
            @(negedge clk);
        end
        bus.w_data = 32'h33;
        rst = 1'b1;
        @(negedge clk);
        chk("mrst_w_ready",  bus.w_ready,  0);
        chk("mrst_b_valid",  bus.b_valid,  0);
        chk("mrst_r_valid",  bus.r_valid,  0);
        chk("mrst_aw_ready", bus.aw_ready, 1);
        rst = 1'b0;
        bus.w_valid = 1'b0;
        read_burst(32'h300, 4'd0, 8'd1, 3'd2, 2'b01);
        chk("mrst_keep0", rd_data[0], 32'h11);
        chk("mrst_keep1", rd_data[1], 32'h22);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
